// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with valid/ready handshakes, iterative shifts and N/Z/C/V flags
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   i_valid, o_ready  input handshake; A, B and Op are latched on i_valid & o_ready
//   i_A, i_B, i_Op    signed operands and 6-bit funct opcode
//   o_valid, i_ready  output handshake; result is held until i_ready
//   o_R               signed result
//   o_flags           {N,Z,C,V}
//   o_err             unsupported opcode on the current result
//
// Optional feature: define ALU_MUL_EN to add an iterative multiplier on opcode 011000.
// Without it, 011000 is reported as unsupported and no multiplier logic exists.
module alu_secuencial #(
    parameter int NBITS = 8,
    parameter int SHW   = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [NBITS-1:0] i_A,
    input  logic [NBITS-1:0] i_B,
    input  logic [5:0]       i_Op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [NBITS-1:0] o_R,
    output logic [3:0]       o_flags,
    output logic             o_err
);
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    // one extra bit so the multiplier can load a count of NBITS
    localparam int CW = SHW + 1;

    logic [1:0]       state;
    logic [NBITS-1:0] a_q, b_q, wr;
    logic [5:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [NBITS:0]   sum, dif;
    logic [NBITS-1:0] lres, sh_nxt;
    logic             lc, lv, is_alu, is_sh, last;

    assign o_ready = state == S_IDLE;
    assign o_valid = state == S_DONE;
    assign is_sh   = op_q == OP_SRA || op_q == OP_SRL;
    assign last    = cnt == CW'(1);
    // SRA refills from the sign of the latched operand A
    assign sh_nxt  = {op_q == OP_SRA ? a_q[NBITS-1] : 1'b0, wr[NBITS-1:1]};

    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        dif    = {1'b0, a_q} - {1'b0, b_q};
        lres   = '0;
        lc     = 1'b0;
        lv     = 1'b0;
        is_alu = 1'b1;
        case (op_q)
            OP_ADD: begin
                lres = sum[NBITS-1:0];
                lc   = sum[NBITS];
                lv   = a_q[NBITS-1] == b_q[NBITS-1] && sum[NBITS-1] != a_q[NBITS-1];
            end
            OP_SUB: begin
                lres = dif[NBITS-1:0];
                lc   = dif[NBITS];
                lv   = a_q[NBITS-1] != b_q[NBITS-1] && dif[NBITS-1] != a_q[NBITS-1];
            end
            OP_AND:  lres = a_q & b_q;
            OP_OR:   lres = a_q | b_q;
            OP_XOR:  lres = a_q ^ b_q;
            OP_NOR:  lres = ~(a_q | b_q);
            default: is_alu = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [5:0] OP_MUL = 6'b011000;
    logic [2*NBITS-1:0] acc, mc, acc_nxt;
    logic [NBITS-1:0]   mp;
    logic               mv;
    // signed shift-add: the multiplier's MSB carries weight -2^(NBITS-1), so it is subtracted
    assign acc_nxt = acc + (mp[0] ? (last ? -mc : mc) : '0);
    // product fits in NBITS only when its upper NBITS+1 bits are all equal
    assign mv = !((&acc_nxt[2*NBITS-1:NBITS-1]) || !(|acc_nxt[2*NBITS-1:NBITS-1]));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            wr      <= '0;
            cnt     <= '0;
            o_R     <= '0;
            o_flags <= '0;
            o_err   <= 1'b0;
`ifdef ALU_MUL_EN
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (i_valid) begin
                    a_q   <= i_A;
                    b_q   <= i_B;
                    op_q  <= i_Op;
                    state <= S_EXEC;
                end
                S_EXEC: if (is_alu) begin
                    o_R     <= lres;
                    o_flags <= {lres[NBITS-1], lres == '0, lc, lv};
                    o_err   <= 1'b0;
                    state   <= S_DONE;
                end else if (is_sh) begin
                    wr  <= a_q;
                    cnt <= {1'b0, b_q[SHW-1:0]};
                    if (b_q[SHW-1:0] == '0) begin
                        o_R     <= a_q;
                        o_flags <= {a_q[NBITS-1], a_q == '0, 2'b00};
                        o_err   <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_SHIFT;
                    end
`ifdef ALU_MUL_EN
                end else if (op_q == OP_MUL) begin
                    cnt   <= CW'(NBITS);
                    acc   <= '0;
                    mc    <= {{NBITS{a_q[NBITS-1]}}, a_q};
                    mp    <= b_q;
                    state <= S_SHIFT;
`endif
                end else begin
                    o_R     <= '0;
                    o_flags <= '0;
                    o_err   <= 1'b1;
                    state   <= S_DONE;
                end
                S_SHIFT: begin
                    cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc <= acc_nxt;
                        mc  <= mc << 1;
                        mp  <= mp >> 1;
                        if (last) begin
                            o_R     <= acc_nxt[NBITS-1:0];
                            o_flags <= {acc_nxt[NBITS-1], acc_nxt[NBITS-1:0] == '0, 1'b0, mv};
                            o_err   <= 1'b0;
                            state   <= S_DONE;
                        end
                    end else begin
`endif
                        wr <= sh_nxt;
                        if (last) begin
                            o_R     <= sh_nxt;
                            o_flags <= {sh_nxt[NBITS-1], sh_nxt == '0, 2'b00};
                            o_err   <= 1'b0;
                            state   <= S_DONE;
                        end
`ifdef ALU_MUL_EN
                    end
`endif
                end
                default: if (i_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: scoreboard bench for alu_secuencial against an arithmetic reference model
module tb_alu_secuencial;
    localparam int N = 8;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110, NOR_ = 6'b100111, SRA = 6'b000011, SRL = 6'b000010;
    localparam logic [5:0] MUL = 6'b011000;

    logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [N-1:0] i_A = '0, i_B = '0;
    logic [5:0] i_Op = '0;
    logic o_ready, o_valid, o_err;
    logic [N-1:0] o_R;
    logic [3:0] o_flags;

    typedef struct {
        logic [N-1:0] r;
        logic [3:0]   f;
        logic         e;
        int           lat;
        longint       t;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int compared = 0, mismatched = 0;
    bit hold = 1'b0, seen = 1'b0;
    logic [5:0] ops [10] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRA, SRL, MUL, 6'b111111};

    alu_secuencial #(.NBITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_A(i_A), .i_B(i_B), .i_Op(i_Op), .o_valid(o_valid), .i_ready(i_ready),
        .o_R(o_R), .o_flags(o_flags), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t x;
        int ua = int'(a), ub = int'(b);
        int sa = int'($signed(a)), sb = int'($signed(b));
        int sh = ub % N, full;
        int lo = -(1 << (N - 1)), hi = (1 << (N - 1)) - 1;
        x.r = '0; x.f = '0; x.e = 1'b0; x.lat = 1; x.t = 0;
        case (op)
            ADD: begin
                x.r = N'(ua + ub);
                x.f[1] = (ua + ub) > ((1 << N) - 1);
                full = sa + sb;
                x.f[0] = full < lo || full > hi;
            end
            SUB: begin
                x.r = N'(ua - ub);
                x.f[1] = ua < ub;
                full = sa - sb;
                x.f[0] = full < lo || full > hi;
            end
            AND_: x.r = a & b;
            OR_:  x.r = a | b;
            XOR_: x.r = a ^ b;
            NOR_: x.r = ~(a | b);
            SRA: begin x.r = N'(sa >>> sh); x.lat = 1 + sh; end
            SRL: begin x.r = N'(ua >> sh); x.lat = 1 + sh; end
`ifdef ALU_MUL_EN
            MUL: begin
                full = sa * sb;
                x.r = N'(full);
                x.f[0] = full < lo || full > hi;
                x.lat = N + 1;
            end
`endif
            default: x.e = 1'b1;
        endcase
        if (!x.e) begin
            x.f[3] = x.r[N-1];
            x.f[2] = x.r == '0;
        end
        return x;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int n = 0;
        do begin @(negedge clk); n++; end while (!o_ready && n < 300);
        if (!o_ready) begin
            chk("issue_timeout_ready", o_ready, 1);
            return;
        end
        i_valid = 1'b1; i_Op = op; i_A = a; i_B = b;
        @(posedge clk);
        e = model(op, a, b);
        e.t = $time;
        q.push_back(e);
        #1;
        i_valid = 1'b0; i_A = N'($urandom); i_B = N'($urandom); i_Op = 6'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q.size() != 0 || !o_ready); i++) @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_R"}, o_R, 0);
        chk({tag, "_flags"}, o_flags, 0);
        chk({tag, "_err"}, o_err, 0);
    endtask

    // monitor: result checks on the first cycle o_valid is seen, stability checks while held
    initial forever begin
        @(negedge clk);
        i_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (!rst_n) begin
            seen = 1'b0;
        end else if (o_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output actual R=%0h required no output", o_R);
            end else begin
                cur = q.pop_front();
                chk("R", o_R, cur.r);
                chk("flags", o_flags, cur.f);
                chk("err", o_err, cur.e);
                chk("latency", 32'(($time - cur.t - 5) / 10), cur.lat);
            end
        end else if (o_valid) begin
            chk("hold_R", o_R, cur.r);
            chk("hold_flags", o_flags, cur.f);
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(ADD, 8'h7F, 8'h01);
        issue(SUB, 8'h00, 8'h01);
        issue(SRA, 8'h90, 8'h03);
        issue(SRL, 8'h90, 8'h03);
        issue(SRA, 8'h90, 8'hF8);
        issue(SRL, 8'h81, 8'h07);
        issue(6'b111111, 8'h12, 8'h34);
        issue(MUL, 8'hFD, 8'h05);
        issue(MUL, 8'h40, 8'h04);
        drain();

        // backpressure: result held, o_ready low and a second request ignored
        @(posedge clk);
        #1 hold = 1'b1;
        issue(XOR_, 8'hAA, 8'hAA);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            i_valid = 1'b1; i_Op = ADD; i_A = N'($urandom); i_B = N'($urandom);
        end
        i_valid = 1'b0;
        hold = 1'b0;
        drain();

        // reset in the middle of a shift discards the operation
        issue(SRL, 8'hFF, 8'h07);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(ADD, 8'h05, 8'h03);
        drain();

        repeat (200) issue(ops[$urandom_range(0, 9)], N'($urandom), N'($urandom));
        issue(ADD, 8'hFF, 8'h01);
        issue(SUB, 8'h80, 8'h01);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
